// File: rtl/alu_exec_stage_if.sv
// Handshake and result bus between operand fetch, the ALU execute stage and writeback.
// The master drives the operation and out_ready. The slave (the execute stage) returns the result and flags.
interface alu_exec_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
    );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle logic/arithmetic, iterative 1-bit/cycle shifts and rotates,
// registered result and flags held until writeback accepts them.
//
// state | meaning
// IDLE  | ready for a new operation (in_ready=1)
// SHIFT | iterating shift/rotate, one bit per cycle
// DONE  | result/flags valid, waiting for out_ready
module alu_exec_stage #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input logic             clk,
    input logic             rst,
    alu_exec_stage_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

    logic             accept;
    logic             is_shift_in;
    logic [SHW-1:0]   k_in;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] step_res;
    logic             step_out;
    logic             load;
    logic [WIDTH-1:0] new_res;
    logic             new_c, new_v;

    assign accept      = bus.in_valid && (state_q == S_IDLE);
    assign is_shift_in = bus.op[2] && (bus.op[1] || bus.op[0]);
    assign k_in        = bus.b[SHW-1:0];
    assign sum         = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff        = {1'b0, bus.a} - {1'b0, bus.b};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = (is_shift_in && (k_in != '0)) ? S_SHIFT : S_DONE;
            S_SHIFT: if (cnt_q == SHW'(1)) state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One step of the iterative shifter; only meaningful while in SHIFT.
    always_comb begin
        case (op_q)
            OP_SHL: begin
                step_res = {sh_q[WIDTH-2:0], 1'b0};
                step_out = sh_q[WIDTH-1];
            end
            OP_SHR: begin
                step_res = {1'b0, sh_q[WIDTH-1:1]};
                step_out = sh_q[0];
            end
            default: begin
                step_res = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
                step_out = sh_q[WIDTH-1];
            end
        endcase
    end

    always_comb begin
        op_d    = op_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        new_res = result_q;
        new_c   = 1'b0;
        new_v   = 1'b0;

        if (accept) begin
            op_d = bus.op;
            case (bus.op)
                OP_ADD: begin
                    load    = 1'b1;
                    new_res = sum[WIDTH-1:0];
                    new_c   = sum[WIDTH];
                    new_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_SUB: begin
                    load    = 1'b1;
                    new_res = diff[WIDTH-1:0];
                    new_c   = diff[WIDTH];
                    new_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_AND: begin
                    load    = 1'b1;
                    new_res = bus.a & bus.b;
                end
                OP_OR: begin
                    load    = 1'b1;
                    new_res = bus.a | bus.b;
                end
                OP_XOR: begin
                    load    = 1'b1;
                    new_res = bus.a ^ bus.b;
                end
                default: begin
                    if (k_in == '0) begin
                        load    = 1'b1;
                        new_res = bus.a;
                    end else begin
                        sh_d  = bus.a;
                        cnt_d = k_in;
                    end
                end
            endcase
        end else if (state_q == S_SHIFT) begin
            sh_d  = step_res;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                load    = 1'b1;
                new_res = step_res;
                new_c   = step_out;
            end
        end

        result_d = load ? new_res : result_q;
        z_d      = load ? (new_res == '0) : z_q;
        n_d      = load ? new_res[WIDTH-1] : n_q;
        c_d      = load ? new_c : c_q;
        v_d      = load ? new_v : v_q;
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.result    = result_q;
        bus.flag_z    = z_q;
        bus.flag_n    = n_q;
        bus.flag_c    = c_q;
        bus.flag_v    = v_q;
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table for single operations plus
// hand sequences for backpressure and reset during a shift.
module tb_alu_exec_stage;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ROL = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z, n, c, v;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs[16];

    alu_exec_stage_if #(.WIDTH(16)) bus ();

    alu_exec_stage #(.WIDTH(16), .SHW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic z, input logic n, input logic c, input logic v);
        check({name, " Z"}, 32'(bus.flag_z), 32'(z));
        check({name, " N"}, 32'(bus.flag_n), 32'(n));
        check({name, " C"}, 32'(bus.flag_c), 32'(c));
        check({name, " V"}, 32'(bus.flag_v), 32'(v));
    endtask

    // Entered and left at a negedge with the DUT idle; out_ready is 1 throughout.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        string nm;
        nm = $sformatf("vec%0d", idx);
        bus.op       = v.op;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op       = ~v.op;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check({nm, " busy in_ready"}, 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check({nm, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({nm, " latency"}, 32'(lat), 32'(v.lat));
        check({nm, " result"}, 32'(bus.result), 32'(v.res));
        check_flags(nm, v.z, v.n, v.c, v.v);
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        vec_t rv;
        n_checks = 0;
        n_errors = 0;

        //           op      a         b         res       z     n     c     v     lat
        vecs[0]  = '{OP_XOR, 16'd15,   16'd3,    16'd12,   1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{OP_XOR, 16'd16,   16'd9,    16'd25,   1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[3]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[4]  = '{OP_SUB, 16'd3,    16'd5,    16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[5]  = '{OP_SHL, 16'h1001, 16'd4,    16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 5};
        vecs[6]  = '{OP_SHR, 16'h00F0, 16'd0,    16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{OP_ROL, 16'h8001, 16'd1,    16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[8]  = '{OP_SUB, 16'd5,    16'd3,    16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[10] = '{OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{OP_AND, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{OP_ROL, 16'h8001, 16'hFFFF, 16'hC000, 1'b0, 1'b1, 1'b0, 1'b0, 16};
        vecs[13] = '{OP_SHR, 16'h0003, 16'h0012, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3};
        vecs[14] = '{OP_SHL, 16'hFFFF, 16'h000F, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 16};
        vecs[15] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Backpressure: result held while out_ready=0, a request during the stall is not taken.
        bus.out_ready = 1'b0;
        bus.op        = OP_AND;
        bus.a         = 16'h00FF;
        bus.b         = 16'h0F0F;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("stall%0d out_valid", s), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall%0d result", s), 32'(bus.result), 32'h000F);
            check($sformatf("stall%0d in_ready", s), 32'(bus.in_ready), 32'd0);
            if (s == 1) begin
                bus.op       = OP_XOR;
                bus.a        = 16'h00F0;
                bus.b        = 16'h000F;
                bus.in_valid = 1'b1;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", 32'(bus.out_valid), 32'd0);
        check("release in_ready", 32'(bus.in_ready), 32'd1);
        check("release held result", 32'(bus.result), 32'h000F);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("next op out_valid", 32'(bus.out_valid), 32'd1);
        check("next op result", 32'(bus.result), 32'h00FF);
        @(negedge clk);

        // Reset during SHIFT, with a competing in_valid on the reset edge.
        bus.op       = OP_SHL;
        bus.a        = 16'h1234;
        bus.b        = 16'd10;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid-shift in_ready", 32'(bus.in_ready), 32'd0);
        rst          = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = 16'h0001;
        bus.b        = 16'h0001;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort result", 32'(bus.result), 32'd0);
        check_flags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("no stale out_valid", 32'(seen), 32'd0);

        rv = '{OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        run_vec(16, rv);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
